// File: rtl/sbox_sched.sv
// sbox_sched: time-shares a pool of NUM_SBOX S-box lanes between a 128-bit
// SubBytes state job and a 32-bit SubWord key job. Each cycle one requester
// gets the whole pool for one batch.
//
// The batch pointer alternates between the two requesters only in cycles
// where both are running. After reset it reads "last = state", so the key
// slot wins the first conflict.
//
// Optional macro SBOX_SCHED_PERF_EN adds the perf_busy and perf_stall
// counters. Both saturate at 0xFFFF.
module sbox_sched #(
  parameter int NUM_SBOX = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         st_valid,
  output logic         st_ready,
  input  logic [127:0] st_in,
  output logic [127:0] st_out,
  output logic         st_done,
  input  logic         kw_valid,
  output logic         kw_ready,
  input  logic [31:0]  kw_in,
  output logic [31:0]  kw_out,
  output logic         kw_done
`ifdef SBOX_SCHED_PERF_EN
  ,
  output logic [15:0]  perf_busy,
  output logic [15:0]  perf_stall
`endif
);

  localparam int SB = 16 / NUM_SBOX;
  localparam int KB = 4 / NUM_SBOX;

  // Reject pool sizes that do not divide a 32-bit key word evenly
  generate
    if (NUM_SBOX != 1 && NUM_SBOX != 2 && NUM_SBOX != 4) begin : g_bad_num_sbox
      $error("sbox_sched: NUM_SBOX must be 1, 2 or 4");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} slot_t;

  slot_t        st_state, st_next, kw_state, kw_next;
  logic [3:0]   st_cnt;
  logic [1:0]   kw_cnt;
  logic [127:0] st_buf;
  logic [31:0]  kw_buf;
  logic         st_last;
  logic         grant_st, grant_kw, both_run;
  logic [7:0]   pool_in  [NUM_SBOX];
  logic [7:0]   pool_out [NUM_SBOX];

  // GF(2^8) multiply, AES polynomial x^8+x^4+x^3+x+1
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // AES S-box: multiplicative inverse (x^254) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = x;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^
           {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  assign st_ready = (st_state == IDLE);
  assign kw_ready = (kw_state == IDLE);
  assign st_done  = (st_state == DONE);
  assign kw_done  = (kw_state == DONE);
  assign both_run = (st_state == RUN) && (kw_state == RUN);

  // Grant the pool: a lone running slot wins; on conflict alternate
  always_comb begin
    grant_st = 1'b0;
    grant_kw = 1'b0;
    if (both_run) begin
      grant_kw = st_last;
      grant_st = !st_last;
    end else begin
      grant_st = (st_state == RUN);
      grant_kw = (kw_state == RUN);
    end
  end

  // Next-state logic of the two slot FSMs
  always_comb begin
    st_next = st_state;
    kw_next = kw_state;
    case (st_state)
      IDLE:    if (st_valid) st_next = RUN;
      RUN:     if (grant_st && st_cnt == 4'(SB - 1)) st_next = DONE;
      DONE:    st_next = IDLE;
      default: st_next = IDLE;
    endcase
    case (kw_state)
      IDLE:    if (kw_valid) kw_next = RUN;
      RUN:     if (grant_kw && kw_cnt == 2'(KB - 1)) kw_next = DONE;
      DONE:    kw_next = IDLE;
      default: kw_next = IDLE;
    endcase
  end

  // Steer the granted requester's current batch bytes into the pool
  always_comb begin
    for (int k = 0; k < NUM_SBOX; k++) begin
      pool_in[k] = 8'h00;
      if (grant_st)
        pool_in[k] = st_buf[8*(int'(st_cnt)*NUM_SBOX + k) +: 8];
      else if (grant_kw)
        pool_in[k] = kw_buf[8*(int'(kw_cnt)*NUM_SBOX + k) +: 8];
      pool_out[k] = sbox(pool_in[k]);
    end
  end

  // Slot state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_state <= IDLE;
      kw_state <= IDLE;
    end else begin
      st_state <= st_next;
      kw_state <= kw_next;
    end
  end

  // Round-robin pointer, moved only by conflict cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) st_last <= 1'b1;
    else if (both_run) st_last <= grant_st;
  end

  // Input capture, batch counters and lane-wise result write-back
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_buf <= '0;
      kw_buf <= '0;
      st_cnt <= '0;
      kw_cnt <= '0;
      st_out <= '0;
      kw_out <= '0;
    end else begin
      if (st_valid && st_ready) begin
        st_buf <= st_in;
        st_cnt <= '0;
      end else if (grant_st) begin
        st_cnt <= st_cnt + 4'd1;
        for (int k = 0; k < NUM_SBOX; k++)
          st_out[8*(int'(st_cnt)*NUM_SBOX + k) +: 8] <= pool_out[k];
      end
      if (kw_valid && kw_ready) begin
        kw_buf <= kw_in;
        kw_cnt <= '0;
      end else if (grant_kw) begin
        kw_cnt <= kw_cnt + 2'd1;
        for (int k = 0; k < NUM_SBOX; k++)
          kw_out[8*(int'(kw_cnt)*NUM_SBOX + k) +: 8] <= pool_out[k];
      end
    end
  end

`ifdef SBOX_SCHED_PERF_EN
  // Saturating counters of pool-busy cycles and denied running slots
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_busy  <= '0;
      perf_stall <= '0;
    end else begin
      if ((grant_st || grant_kw) && perf_busy != 16'hffff)
        perf_busy <= perf_busy + 16'd1;
      if (both_run && perf_stall != 16'hffff)
        perf_stall <= perf_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sbox_sched.sv
// tb_sbox_sched: directed checks of sbox_sched with pool sizes 4, 2 and 1.
module tb_sbox_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  // Pool of 4
  logic a_st_valid = 0, a_kw_valid = 0;
  logic a_st_ready, a_kw_ready, a_st_done, a_kw_done;
  logic [127:0] a_st_in = '0, a_st_out;
  logic [31:0]  a_kw_in = '0, a_kw_out;
  // Pool of 2
  logic b_st_valid = 0, b_kw_valid = 0;
  logic b_st_ready, b_kw_ready, b_st_done, b_kw_done;
  logic [127:0] b_st_in = '0, b_st_out;
  logic [31:0]  b_kw_in = '0, b_kw_out;
  // Pool of 1
  logic c_st_valid = 0, c_kw_valid = 0;
  logic c_st_ready, c_kw_ready, c_st_done, c_kw_done;
  logic [127:0] c_st_in = '0, c_st_out;
  logic [31:0]  c_kw_in = '0, c_kw_out;

  sbox_sched #(.NUM_SBOX(4)) u4 (
    .clk(clk), .rst(rst),
    .st_valid(a_st_valid), .st_ready(a_st_ready), .st_in(a_st_in),
    .st_out(a_st_out), .st_done(a_st_done),
    .kw_valid(a_kw_valid), .kw_ready(a_kw_ready), .kw_in(a_kw_in),
    .kw_out(a_kw_out), .kw_done(a_kw_done));

  sbox_sched #(.NUM_SBOX(2)) u2 (
    .clk(clk), .rst(rst),
    .st_valid(b_st_valid), .st_ready(b_st_ready), .st_in(b_st_in),
    .st_out(b_st_out), .st_done(b_st_done),
    .kw_valid(b_kw_valid), .kw_ready(b_kw_ready), .kw_in(b_kw_in),
    .kw_out(b_kw_out), .kw_done(b_kw_done));

  sbox_sched #(.NUM_SBOX(1)) u1 (
    .clk(clk), .rst(rst),
    .st_valid(c_st_valid), .st_ready(c_st_ready), .st_in(c_st_in),
    .st_out(c_st_out), .st_done(c_st_done),
    .kw_valid(c_kw_valid), .kw_ready(c_kw_ready), .kw_in(c_kw_in),
    .kw_out(c_kw_out), .kw_done(c_kw_done));

  // Advance to 1 time unit after the next rising edge
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset values
    tick(2);
    check("rst_st_ready", 128'(a_st_ready), 128'd1);
    check("rst_kw_ready", 128'(a_kw_ready), 128'd1);
    check("rst_st_out", a_st_out, 128'd0);
    check("rst_kw_out", 128'(a_kw_out), 128'd0);
    check("rst_dones", 128'({a_st_done, a_kw_done}), 128'd0);
    rst = 1'b0;
    tick();

    // State all 0x00 on pool of 4: done at t+5, ready back at t+6
    a_st_in = '0; a_st_valid = 1;
    tick(); a_st_valid = 0;                                  // t+1
    check("s0_ready_low", 128'(a_st_ready), 128'd0);
    tick(3);                                                 // t+4
    check("s0_no_early_done", 128'(a_st_done), 128'd0);
    tick();                                                  // t+5
    check("s0_done", 128'(a_st_done), 128'd1);
    check("s0_out", a_st_out, {16{8'h63}});
    tick();                                                  // t+6
    check("s0_done_pulse", 128'(a_st_done), 128'd0);
    check("s0_ready_back", 128'(a_st_ready), 128'd1);

    // Key word alone: done at t+2
    a_kw_in = 32'h00010203; a_kw_valid = 1;
    tick(); a_kw_valid = 0;                                  // t+1
    check("k0_no_early_done", 128'(a_kw_done), 128'd0);
    tick();                                                  // t+2
    check("k0_done", 128'(a_kw_done), 128'd1);
    check("k0_out", 128'(a_kw_out), 128'(32'h637c777b));
    tick();

    // Simultaneous handshakes: key first, state t+2..t+5
    a_st_in = {16{8'h53}}; a_kw_in = 32'h53535353;
    a_st_valid = 1; a_kw_valid = 1;
    tick(); a_st_valid = 0; a_kw_valid = 0;                  // t+1
    check("c_kw_not_yet", 128'(a_kw_done), 128'd0);
    tick();                                                  // t+2
    check("c_kw_done", 128'(a_kw_done), 128'd1);
    check("c_kw_out", 128'(a_kw_out), 128'(32'hedededed));
    tick(3);                                                 // t+5
    check("c_st_not_yet", 128'(a_st_done), 128'd0);
    tick();                                                  // t+6
    check("c_st_done", 128'(a_st_done), 128'd1);
    check("c_st_out", a_st_out, {16{8'hed}});
    tick();

    // Pool of 1, bytes 0x00..0x0f: done at t+17
    c_st_in = 128'h0f0e0d0c0b0a09080706050403020100; c_st_valid = 1;
    tick(); c_st_valid = 0;                                  // t+1
    tick(15);                                                // t+16
    check("n1_not_yet", 128'(c_st_done), 128'd0);
    tick();                                                  // t+17
    check("n1_done", 128'(c_st_done), 128'd1);
    check("n1_out", c_st_out, 128'h76abd7fe2b670130c56f6bf27b777c63);
    tick();

    // Pool of 2: state at t, key at t+2; state finishes at t+11, key at t+6
    b_st_in = {16{8'h01}}; b_st_valid = 1;
    tick(); b_st_valid = 0;                                  // t+1
    tick();                                                  // t+2
    b_kw_in = 32'h09090909; b_kw_valid = 1;
    tick(); b_kw_valid = 0;                                  // t+3
    tick(2);                                                 // t+5
    check("n2_kw_delayed", 128'(b_kw_done), 128'd0);
    tick();                                                  // t+6
    check("n2_kw_done", 128'(b_kw_done), 128'd1);
    check("n2_kw_out", 128'(b_kw_out), 128'(32'h01010101));
    tick(3);                                                 // t+9
    check("n2_st_delayed", 128'(b_st_done), 128'd0);
    tick();                                                  // t+10
    check("n2_st_not_yet", 128'(b_st_done), 128'd0);
    tick();                                                  // t+11
    check("n2_st_done", 128'(b_st_done), 128'd1);
    check("n2_st_out", b_st_out, {16{8'h7c}});
    tick();

    // Reset during a running state job on pool of 4
    a_st_in = {16{8'h00}}; a_st_valid = 1;
    tick(); a_st_valid = 0;                                  // t+1
    tick();                                                  // t+2
    rst = 1'b1;
    #1;
    check("mr_out_cleared", a_st_out, 128'd0);
    check("mr_kw_cleared", 128'(a_kw_out), 128'd0);
    check("mr_ready", 128'(a_st_ready), 128'd1);
    tick(); rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("mr_no_done", 128'(a_st_done), 128'd0);
      tick();
    end
    a_st_in = {16{8'h53}}; a_st_valid = 1;
    tick(); a_st_valid = 0;                                  // t+1
    tick(3);                                                 // t+4
    check("mr2_not_yet", 128'(a_st_done), 128'd0);
    tick();                                                  // t+5
    check("mr2_done", 128'(a_st_done), 128'd1);
    check("mr2_out", a_st_out, {16{8'hed}});
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
